// File: rtl/oai22_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : oai22_rr_sched
// Purpose  : Round-robin scheduler that time-shares one external OAI22 gate,
//            out = ~((in0|in1) & (in2|in3)), among NREQ requesters. One
//            requester is granted at a time. Its operand set is registered
//            and driven onto the gate. The gate result is sampled one cycle
//            later and returned with the owner's id over a val/rdy response.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NREQ       number of requesters (2, 4 or 8)
//   IDW        requester id width, $clog2(NREQ)
// Ports
//   clk        clock, rising-edge active
//   reset      asynchronous active-high reset
//   req_val    [NREQ]    per-requester operand-valid
//   req_rdy    [NREQ]    per-requester accept, at most one bit high
//   req_data   [4*NREQ]  operand sets, slice i = {in3,in2,in1,in0}
//   gate_in0..gate_in3   operands to the shared OAI22 gate
//   gate_out             combinational result from the shared gate
//   resp_val / resp_rdy  response handshake
//   resp_data            registered gate result
//   resp_id   [IDW]      owner of resp_data
//   busy                 high whenever the scheduler is not idle
// ============================================================================
module oai22_rr_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_val,
    output logic [NREQ-1:0]   req_rdy,
    input  logic [4*NREQ-1:0] req_data,
    output logic              gate_in0,
    output logic              gate_in1,
    output logic              gate_in2,
    output logic              gate_in3,
    input  logic              gate_out,
    output logic              resp_val,
    input  logic              resp_rdy,
    output logic              resp_data,
    output logic [IDW-1:0]    resp_id,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [IDW-1:0]  ptr;         // highest-priority requester for next grant
    logic [3:0]      operand;     // {in3,in2,in1,in0} of the granted request
    logic            result;      // gate output captured during EVAL
    logic [IDW-1:0]  owner_id;    // id of the request being served

    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  scan_idx;
    logic [3:0]      grant_data;
    logic            fire;

    // ------------------------------------------------------------------------
    // Rotating priority search. NREQ is a power of two, so adding the scan
    // offset to ptr in IDW bits wraps modulo NREQ for free.
    // ------------------------------------------------------------------------
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = ptr + IDW'(k);
            if (!grant_found && req_val[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // Operand slice of the winning requester.
    always_comb begin
        grant_data = 4'b0000;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                grant_data = req_data[4*i +: 4];
            end
        end
    end

    // Grants are only offered in IDLE; the winner is by construction valid,
    // so a grant and a fire are the same event.
    assign fire = (state == IDLE) && grant_found;

    // One-hot ready decode.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rdy
            assign req_rdy[gi] = fire && (grant_idx == IDW'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and handshake outputs. resp_val and busy decode straight
    // from the state register so an asynchronous reset drops them at once.
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        resp_val  = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (fire) begin
                    state_nxt = EVAL;
                end
            end
            EVAL: begin
                state_nxt = RESP;
            end
            RESP: begin
                resp_val = 1'b1;
                // No new request is considered in the response-fire cycle;
                // the next grant waits for IDLE.
                if (resp_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy      = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr      <= '0;
            operand  <= 4'b0000;
            owner_id <= '0;
        end else if (fire) begin
            ptr      <= grant_idx + IDW'(1);
            operand  <= grant_data;
            owner_id <= grant_idx;
        end
    end

    // gate_out is meaningful only while the registered operands have been on
    // the gate for a full cycle, i.e. in EVAL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= 1'b0;
        end else if (state == EVAL) begin
            result <= gate_out;
        end
    end

    // The gate is always driven from the operand register, in every state.
    assign gate_in0  = operand[0];
    assign gate_in1  = operand[1];
    assign gate_in2  = operand[2];
    assign gate_in3  = operand[3];

    assign resp_data = result;
    assign resp_id   = owner_id;

endmodule
`default_nettype wire

// File: doc/oai22_rr_sched.md
Name: oai22_rr_sched

Overview:
- Round-robin scheduler that shares one external OAI22 gate, out = ~((in0|in1)&(in2|in3)), among NREQ requesters.
- Each requester presents a 4-bit operand set over a val/rdy handshake.
- The scheduler grants one requester and drives the shared gate from a registered operand set.
- It samples the gate output and returns the 1-bit result, tagged with the requester id, over a val/rdy response interface.

Parameters:
- NREQ, 4: number of requesters. Legal values are 2, 4 or 8.
- IDW, $clog2(NREQ): width of the requester id.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_val  input  NREQ  bit i: requester i has a valid operand set.
- req_rdy  output  NREQ  bit i: scheduler accepts requester i this cycle. At most one bit is high.
- req_data  input  4*NREQ  bits [4i+3:4i] of requester i map to {in3,in2,in1,in0}.
- gate_in0, gate_in1, gate_in2, gate_in3  output  1 each  operands driven to the shared OAI22 gate.
- gate_out  input  1  combinational result returned by the shared gate.
- resp_val  output  1  result valid.
- resp_rdy  input  1  consumer accepts the result.
- resp_data  output  1  registered gate result.
- resp_id  output  IDW  id of the requester that owns resp_data.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- State machine: IDLE, EVAL, RESP. All registers reset asynchronously.
- Reset values:
  - state = IDLE, ptr = 0, operand register = 4'b0000 (so all gate_in* = 0).
  - result register = 0, id register = 0.
  - Outputs: resp_val = 0, resp_data = 0, resp_id = 0, req_rdy = 0, busy = 0.
- Grant selection (IDLE only, combinational):
  - g = first index i with req_val[i] = 1, scanning ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
  - req_rdy = one-hot(g) if any req_val is high, otherwise 0.
  - req_rdy is 0 in EVAL and RESP.
- Request fire = req_val[g] & req_rdy[g]. On fire in cycle t:
  - operand register <= req_data slice g; id register <= g.
  - ptr <= (g+1) mod NREQ; state <= EVAL.
- EVAL (cycle t+1):
  - gate_in* are driven from the operand register. They are always driven from it, in every state.
  - result register <= gate_out at the end of the cycle; state <= RESP.
- RESP (cycle t+2 onward):
  - resp_val = 1; resp_data and resp_id come from registers and are stable while stalled.
  - On resp_val & resp_rdy: state <= IDLE; resp_val drops the next cycle.
  - ptr and the operand register are unchanged while stalled.
- Latency and throughput:
  - Request fire to resp_val is 2 cycles.
  - With resp_rdy held at 1, a new request can fire at the earliest in cycle t+3, so peak throughput is one result per 3 cycles.
  - The scheduler accepts no request in the same cycle as a response fire.
- Requester obligations:
  - Once raised, req_val and req_data must hold until fire.
  - req_val must not depend combinationally on req_rdy.
  - A requester that is not granted simply waits; no request is dropped.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0,... A requester waits at most NREQ-1 other grants.
- Wrap-around: when ptr = NREQ-1 and requester NREQ-1 is granted, ptr wraps to 0.
- No requests: the scheduler stays in IDLE, ptr is unchanged and req_rdy = 0.
- Reset mid-operation (any state):
  - The in-flight transaction is discarded.
  - resp_val and busy drop immediately (asynchronously) and ptr returns to 0.
  - No response is ever issued for a request that fired before reset.
- gate_out is only sampled in EVAL; its value in other states is ignored.

Test Plan:
- Reset then single request: req_val = 4'b0100, req_data[11:8] = 4'b0101 (in0=1, in2=1).
  - Fire at cycle t; gate_in* = {in3..in0} = 0101 at t+1.
  - resp_val = 1, resp_data = 0, resp_id = 2 at t+2; busy high over t+1..t+2.
- Operand sweep on requester 0 with resp_rdy = 1, all 16 operand values. Expected resp_data:
  - 1 for operands 0000, 0001, 0010, 0011, 0100, 1000, 1100.
  - 0 for all other operands.
  - Consecutive fires are exactly 3 cycles apart.
- Round-robin with all four req_val held at 1 and resp_rdy = 1:
  - resp_id sequence is 0,1,2,3,0,1 over 18 cycles.
  - req_rdy is one-hot in every IDLE cycle.
- Backpressure: hold resp_rdy = 0 for 5 cycles in RESP.
  - resp_val, resp_data and resp_id stay constant; req_rdy = 0.
  - Raise resp_rdy: the response fires once and a pending request fires the cycle after.
- Wrap and skip: after grants of requesters 1 and 3, assert only requester 2. Requester 2 is granted (ptr = 0 scan), then ptr = 3.
- Async reset asserted mid-EVAL, between clock edges:
  - busy = 0, resp_val = 0 and gate_in* = 0 immediately.
  - After release, the next grant starts from requester 0 and no stale response appears.
